// File: rtl/mimi_mem_pkg.sv
// Shared types and constants for the minimax shared-SRAM arbiter.
package mimi_mem_pkg;

  localparam int SRAM_AW    = 9;
  localparam int BANK_BYTES = 2048;
  localparam int WORD_BYTES = 4;

  typedef enum logic [1:0] {IDLE, RD, RMW_RD, RMW_WR} state_e;
  typedef enum logic [1:0] {G_NONE, G_DATA, G_WB, G_INST} grant_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  mask);
    logic [31:0] r;
    for (int i = 0; i < WORD_BYTES; i++)
      r[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/mimi_mem_rdmux.sv
// Holds the bank index of the access in flight and steers that bank's read data back.
module mimi_mem_rdmux
  import mimi_mem_pkg::*;
#(
  parameter int NBANKS = 4,
  parameter int BW     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [BW-1:0]          bank_i,
  input  logic                   oor_i,
  input  logic [NBANKS*32-1:0]   sram_rdata,
  output logic [31:0]            rdata
);

  logic [BW-1:0] bank_q, bank_d;
  logic          oor_q, oor_d;

  always_comb begin
    bank_d = bank_q;
    oor_d  = oor_q;
    if (load) begin
      bank_d = bank_i;
      oor_d  = oor_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q <= '0;
      oor_q  <= 1'b0;
    end else begin
      bank_q <= bank_d;
      oor_q  <= oor_d;
    end
  end

  // Compare-per-bank keeps the select in range for non power-of-two NBANKS.
  always_comb begin
    rdata = '0;
    for (int b = 0; b < NBANKS; b++)
      if (!oor_q && bank_q == BW'(b)) rdata = sram_rdata[32*b +: 32];
  end

endmodule

// File: rtl/mimi_mem_arbiter.sv
// Shared-SRAM arbiter: CPU data > Wishbone > CPU fetch, with a starvation override for WB.
// Define MIMI_MEM_RMW_EN to build read-modify-write for partial byte masks.
module mimi_mem_arbiter
  import mimi_mem_pkg::*;
#(
  parameter int          NBANKS      = 4,
  parameter int          PC_BITS     = 10,
  parameter logic [31:0] WB_BASE     = 32'h3000_0000,
  parameter int          WB_MAX_WAIT = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   inst_req,
  input  logic [PC_BITS-1:0]     inst_addr,
  output logic [15:0]            inst_rdata,
  output logic                   inst_valid,
  input  logic                   d_rreq,
  input  logic [3:0]             d_wmask,
  input  logic [31:0]            d_addr,
  input  logic [31:0]            d_wdata,
  output logic [31:0]            d_rdata,
  output logic                   d_ack,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  output logic [NBANKS-1:0]      sram_en,
  output logic [SRAM_AW-1:0]     sram_addr,
  output logic                   sram_wen,
  output logic [31:0]            sram_wdata,
  input  logic [NBANKS*32-1:0]   sram_rdata
);

  localparam int              BW        = (NBANKS > 1) ? $clog2(NBANKS) : 1;
  localparam int              CW        = (WB_MAX_WAIT > 0) ? $clog2(WB_MAX_WAIT + 1) : 1;
  localparam logic [31:0]     MEM_BYTES = 32'(NBANKS * BANK_BYTES);
  localparam logic [CW-1:0]   WAIT_MAX  = CW'(WB_MAX_WAIT);

  state_e        state_q, state_d;
  grant_e        grant_q, grant_d, gsel;
  logic          wr_q, wr_d, half_q, half_d;
  logic [CW-1:0] wait_q, wait_d;
  logic          d_ack_q, d_ack_d, wb_ack_q, wb_ack_d, i_vld_q, i_vld_d;
  logic [31:0]   d_rdata_q, d_rdata_d, wb_dat_q, wb_dat_d;
  logic [15:0]   i_rdata_q, i_rdata_d;
`ifdef MIMI_MEM_RMW_EN
  logic [NBANKS-1:0]  ben_q, ben_d;
  logic [SRAM_AW-1:0] word_q, word_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [3:0]         mask_q, mask_d;
`endif

  logic              wb_hit, d_req, wb_req, i_req, load, done;
  logic [31:0]       s_addr, s_wdata, rd_word;
  logic [3:0]        s_mask;
  logic              s_wr, s_oor;
  logic [BW-1:0]     s_bank;
  logic [NBANKS-1:0] s_en;

  // A requester whose ack is showing this cycle is still holding its request; skip it.
  assign wb_hit = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:16] == WB_BASE[31:16]);
  assign d_req  = (d_rreq | (|d_wmask)) & ~d_ack_q;
  assign wb_req = wb_hit & ~wb_ack_q;
  assign i_req  = inst_req & ~i_vld_q;

  always_comb begin : arb
    gsel = G_NONE;
    if (wb_req && (wait_q >= WAIT_MAX || !d_req)) gsel = G_WB;
    else if (d_req)                               gsel = G_DATA;
    else if (i_req)                               gsel = G_INST;
    s_addr  = '0;
    s_mask  = '0;
    s_wdata = '0;
    s_wr    = 1'b0;
    case (gsel)
      G_DATA: begin s_addr = d_addr; s_mask = d_wmask; s_wdata = d_wdata; s_wr = |d_wmask; end
      G_WB:   begin s_addr = {16'h0, wbs_adr_i[15:0]}; s_mask = wbs_sel_i; s_wdata = wbs_dat_i; s_wr = wbs_we_i; end
      G_INST: s_addr = 32'(inst_addr);
      default: ;
    endcase
    s_oor  = s_addr >= MEM_BYTES;
    s_bank = s_addr[11 +: BW];
    s_en   = '0;
    for (int b = 0; b < NBANKS; b++)
      if (!s_oor && s_bank == BW'(b)) s_en[b] = 1'b1;
  end

  mimi_mem_rdmux #(.NBANKS(NBANKS), .BW(BW)) u_rdmux (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .load       (load),
    .bank_i     (s_bank),
    .oor_i      (s_oor),
    .sram_rdata (sram_rdata),
    .rdata      (rd_word)
  );

  always_comb begin : fsm
    state_d   = state_q;
    grant_d   = grant_q;
    wr_d      = wr_q;
    half_d    = half_q;
    wait_d    = wait_q;
    d_ack_d   = 1'b0;
    wb_ack_d  = 1'b0;
    i_vld_d   = 1'b0;
    d_rdata_d = d_rdata_q;
    wb_dat_d  = wb_dat_q;
    i_rdata_d = i_rdata_q;
    load      = 1'b0;
    done      = 1'b0;
    sram_en   = '0;
    sram_addr = '0;
    sram_wen  = 1'b0;
    sram_wdata = '0;
`ifdef MIMI_MEM_RMW_EN
    ben_d   = ben_q;
    word_d  = word_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
`endif
    case (state_q)
      // SRAM strobes are driven straight from the request so reads land one cycle later.
      IDLE: if (!wb_rst_i) begin
        if (wb_req && gsel != G_WB && wait_q < WAIT_MAX) wait_d = wait_q + 1'b1;
        if (gsel != G_NONE) begin
          load      = 1'b1;
          grant_d   = gsel;
          wr_d      = s_wr;
          half_d    = s_addr[1];
          sram_addr = s_addr[2 +: SRAM_AW];
          state_d   = RD;
          if (gsel == G_WB) wait_d = '0;
          if (!s_wr) begin
            sram_en = s_en;
          end else if (s_mask == 4'hf) begin
            sram_en    = s_en;
            sram_wen   = !s_oor;
            sram_wdata = s_wdata;
          end
`ifdef MIMI_MEM_RMW_EN
          else begin
            sram_en = s_en;
            ben_d   = s_en;
            word_d  = s_addr[2 +: SRAM_AW];
            wdata_d = s_wdata;
            mask_d  = s_mask;
            state_d = RMW_RD;
          end
`endif
        end
      end
      RD: begin
        state_d = IDLE;
        done    = 1'b1;
      end
`ifdef MIMI_MEM_RMW_EN
      RMW_RD: begin
        wdata_d = merge_bytes(rd_word, wdata_q, mask_q);
        state_d = RMW_WR;
      end
      RMW_WR: begin
        sram_en    = ben_q;
        sram_addr  = word_q;
        sram_wen   = |ben_q;
        sram_wdata = wdata_q;
        state_d    = IDLE;
        done       = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
    if (done) begin
      case (grant_q)
        G_DATA: begin d_ack_d = 1'b1; if (!wr_q) d_rdata_d = rd_word; end
        G_WB:   begin wb_ack_d = wbs_cyc_i; if (!wr_q) wb_dat_d = rd_word; end
        G_INST: begin i_vld_d = 1'b1; i_rdata_d = half_q ? rd_word[31:16] : rd_word[15:0]; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= IDLE;
      grant_q   <= G_NONE;
      wr_q      <= 1'b0;
      half_q    <= 1'b0;
      wait_q    <= '0;
      d_ack_q   <= 1'b0;
      wb_ack_q  <= 1'b0;
      i_vld_q   <= 1'b0;
      d_rdata_q <= '0;
      wb_dat_q  <= '0;
      i_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      wr_q      <= wr_d;
      half_q    <= half_d;
      wait_q    <= wait_d;
      d_ack_q   <= d_ack_d;
      wb_ack_q  <= wb_ack_d;
      i_vld_q   <= i_vld_d;
      d_rdata_q <= d_rdata_d;
      wb_dat_q  <= wb_dat_d;
      i_rdata_q <= i_rdata_d;
    end
  end

`ifdef MIMI_MEM_RMW_EN
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ben_q   <= '0;
      word_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
    end else begin
      ben_q   <= ben_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
    end
  end
`endif

  assign d_ack      = d_ack_q;
  assign d_rdata    = d_rdata_q;
  assign wbs_ack_o  = wb_ack_q;
  assign wbs_dat_o  = wb_dat_q;
  assign inst_valid = i_vld_q;
  assign inst_rdata = i_rdata_q;

endmodule

// File: tb/tb_mimi_mem_arbiter.sv
// Directed bench for mimi_mem_arbiter with a behavioural 4-bank SRAM model.
module tb_mimi_mem_arbiter;

  localparam int NB    = 4;
  localparam int PCB   = 10;
  localparam int MAXW  = 4;
  localparam int BOUND = 8;
`ifdef MIMI_MEM_RMW_EN
  localparam bit RMW = 1'b1;
`else
  localparam bit RMW = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            inst_req, inst_valid;
  logic [PCB-1:0]  inst_addr;
  logic [15:0]     inst_rdata;
  logic            d_rreq, d_ack;
  logic [3:0]      d_wmask;
  logic [31:0]     d_addr, d_wdata, d_rdata;
  logic            wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_ack_o;
  logic [3:0]      wbs_sel_i;
  logic [31:0]     wbs_adr_i, wbs_dat_i, wbs_dat_o;
  logic [NB-1:0]   sram_en;
  logic [8:0]      sram_addr;
  logic            sram_wen;
  logic [31:0]     sram_wdata;
  logic [NB*32-1:0] sram_rdata;

  int tests = 0;
  int fails = 0;
  int wen_cnt = 0;
  int en_cnt = 0;

  always #5 clk = ~clk;

  mimi_mem_arbiter #(.NBANKS(NB), .PC_BITS(PCB), .WB_BASE(32'h3000_0000), .WB_MAX_WAIT(MAXW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_valid(inst_valid),
    .d_rreq(d_rreq), .d_wmask(d_wmask), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i), .wbs_sel_i(wbs_sel_i),
    .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .sram_en(sram_en), .sram_addr(sram_addr), .sram_wen(sram_wen), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  // SRAM model: strobes latched mid-cycle, acted on at the rising edge.
  logic [31:0]   mem [NB][512];
  logic [NB-1:0] m_en;
  logic          m_wen;
  logic [8:0]    m_addr;
  logic [31:0]   m_wdata;

  always @(negedge clk) begin
    m_en = sram_en; m_wen = sram_wen; m_addr = sram_addr; m_wdata = sram_wdata;
    if (sram_wen) wen_cnt++;
    if (|sram_en) en_cnt++;
  end

  always @(posedge clk)
    for (int b = 0; b < NB; b++)
      if (m_en[b]) begin
        if (m_wen) mem[b][m_addr] <= m_wdata;
        else       sram_rdata[32*b +: 32] <= mem[b][m_addr];
      end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic data_acc(input string tag, input logic rd, input logic [3:0] m,
                          input logic [31:0] a, input logic [31:0] wd, input int exp_lat);
    int n = 0;
    d_rreq = rd; d_wmask = m; d_addr = a; d_wdata = wd;
    do begin tick(); n++; end while (d_ack !== 1'b1 && n < BOUND);
    d_rreq = 1'b0; d_wmask = 4'h0;
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    tick();
    check({tag, "_pulse"}, 32'(d_ack), 32'h0);
  endtask

  task automatic wb_acc(input string tag, input logic we, input logic [31:0] adr,
                        input logic [31:0] dat, input int exp_lat);
    int n = 0;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we; wbs_sel_i = 4'hf;
    wbs_adr_i = adr; wbs_dat_i = dat;
    do begin tick(); n++; end while (wbs_ack_o !== 1'b1 && n < BOUND);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    tick();
    check({tag, "_pulse"}, 32'(wbs_ack_o), 32'h0);
  endtask

  task automatic inst_acc(input string tag, input logic [PCB-1:0] a, input int exp_lat);
    int n = 0;
    inst_req = 1'b1; inst_addr = a;
    do begin tick(); n++; end while (inst_valid !== 1'b1 && n < BOUND);
    inst_req = 1'b0;
    check({tag, "_lat"}, 32'(n), 32'(exp_lat));
    tick();
    check({tag, "_pulse"}, 32'(inst_valid), 32'h0);
  endtask

  initial begin
    int dc, wc, ic, gap, maxgap, n, e0, w0;
    rst = 1'b1;
    inst_req = 0; inst_addr = '0; d_rreq = 0; d_wmask = 0; d_addr = 0; d_wdata = 0;
    wbs_cyc_i = 0; wbs_stb_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_adr_i = 0; wbs_dat_i = 0;
    repeat (2) tick();
    check("rst_en", 32'(sram_en), 32'h0);
    check("rst_strobes", 32'({d_ack, wbs_ack_o, inst_valid, sram_wen}), 32'h0);
    check("rst_data", d_rdata | wbs_dat_o | 32'(inst_rdata) | sram_wdata, 32'h0);
    rst = 1'b0;
    tick();

    // WB write then read back, bank 1 word 1
    wb_acc("t1_wr", 1'b1, 32'h3000_0804, 32'hDEAD_BEEF, 2);
    check("t1_mem", mem[1][1], 32'hDEAD_BEEF);
    wb_acc("t1_rd", 1'b0, 32'h3000_0804, 32'h0, 2);
    check("t1_rdata", wbs_dat_o, 32'hDEAD_BEEF);

    // Partial-mask write
    data_acc("t2_init", 1'b0, 4'hf, 32'h100, 32'h1122_3344, 2);
    data_acc("t2_part", 1'b0, 4'b0010, 32'h100, 32'h0000_AA00, RMW ? 3 : 2);
    data_acc("t2_rd", 1'b1, 4'h0, 32'h100, 32'h0, 2);
    check("t2_word", d_rdata, RMW ? 32'h1122_AA44 : 32'h1122_3344);

    // All three requesters held continuously
    data_acc("t3_init", 1'b0, 4'hf, 32'h200, 32'h5A5A_0F0F, 2);
    d_rreq = 1'b1; d_addr = 32'h200;
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0200;
    inst_req = 1'b1; inst_addr = 10'h200;
    dc = 0; wc = 0; ic = 0; gap = 0; maxgap = 0;
    repeat (40) begin
      tick();
      if (d_ack) dc++;
      if (inst_valid) ic++;
      if (wbs_ack_o) begin wc++; gap = 0; end
      else if (d_ack) begin gap++; if (gap > maxgap) maxgap = gap; end
    end
    check("t3_data_served", 32'(dc >= 8), 32'h1);
    check("t3_wb_served", 32'(wc >= 8), 32'h1);
    check("t3_wb_gap", 32'(maxgap <= MAXW), 32'h1);
    check("t3_fetch_starved", 32'(ic), 32'h0);
    check("t3_d_rdata", d_rdata, 32'h5A5A_0F0F);
    check("t3_wb_rdata", wbs_dat_o, 32'h5A5A_0F0F);
    d_rreq = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    n = 0;
    do begin tick(); n++; end while (inst_valid !== 1'b1 && n < 12);
    check("t3_fetch_served", 32'(inst_valid), 32'h1);
    check("t3_fetch_data", 32'(inst_rdata), 32'h0F0F);
    inst_req = 1'b0;
    repeat (3) tick();

    // Halfword select on fetch
    wb_acc("t4_wr", 1'b1, 32'h3000_0000, 32'hABCD_1234, 2);
    inst_acc("t4_hi", 10'h002, 2);
    check("t4_hi_data", 32'(inst_rdata), 32'hABCD);
    inst_acc("t4_lo", 10'h000, 2);
    check("t4_lo_data", 32'(inst_rdata), 32'h1234);

    // Out of range and top-of-range addresses
    e0 = en_cnt;
    data_acc("t5_wr", 1'b0, 4'hf, 32'h2000, 32'hFFFF_FFFF, 2);
    data_acc("t5_rd", 1'b1, 4'h0, 32'h2000, 32'h0, 2);
    check("t5_no_en", 32'(en_cnt - e0), 32'h0);
    check("t5_rdata", d_rdata, 32'h0);
    data_acc("t5_top_wr", 1'b0, 4'hf, 32'h1FFC, 32'hC0FF_EE01, 2);
    check("t5_top_mem", mem[3][511], 32'hC0FF_EE01);

    // Wrong WB window never acks; dropped cyc suppresses ack
    wb_acc("wb_miss", 1'b0, 32'h3001_0000, 32'h0, BOUND);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = 32'h3000_0804;
    tick();
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    n = 0;
    repeat (4) begin tick(); if (wbs_ack_o) n++; end
    check("wb_drop_noack", 32'(n), 32'h0);

    // Reset in the middle of a partial write
    data_acc("t6_init", 1'b0, 4'hf, 32'h300, 32'h0BAD_F00D, 2);
    w0 = wen_cnt;
    d_wmask = 4'b0001; d_addr = 32'h300; d_wdata = 32'h0000_00EE;
    tick();
    rst = 1'b1;
    #1;
    check("t6_rst_en", 32'(sram_en), 32'h0);
    check("t6_rst_strobes", 32'({sram_wen, d_ack, wbs_ack_o, inst_valid}), 32'h0);
    check("t6_rst_data", d_rdata | wbs_dat_o, 32'h0);
    d_wmask = 4'h0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("t6_no_wen", 32'(wen_cnt - w0), 32'h0);
    data_acc("t6_rd", 1'b1, 4'h0, 32'h300, 32'h0, 2);
    check("t6_word", d_rdata, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
